sum_stationary_dbuf: RTL and testbench
======================================

# sum_stationary_dbuf

Parametrised successor to the square sum-stationary matrix multiplier. It computes C = A·B for a ROWS×K by K×COLS problem on a ROWS×COLS grid of output-stationary multiply-accumulate cells. K is set per job, and the multiplier supports a selectable signed/unsigned mode. The result drain is double-buffered, so job n+1 streams in while job n's result streams out. It sits between the operand feeders (one A column and one B row per beat) and the result consumer (one C row or column per beat).

## Interface
- DATA_WIDTH, 8, operand width
- ROWS, 4, rows of C and A; number of A lanes
- COLS, 4, columns of C and B; number of B lanes
- COUNTER_BITS, 16, width of len_input and the internal counters
- ACC_WIDTH, 32, accumulator and output element width; arithmetic wraps modulo 2^ACC_WIDTH
- OUT_LANES, max(ROWS,COLS), derived; output lane count
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- input_valid  in  1  operand beat present
- input_ready  out  1  block accepts operand beat
- len_input  in  COUNTER_BITS  K; sampled on a job's first accepted beat
- signed_mode  in  1  1 = two's-complement operands; sampled on a job's first accepted beat
- a_data  in  DATA_WIDTH×ROWS  column k of A, lane i = A[i][k]
- b_data  in  DATA_WIDTH×COLS  row k of B, lane j = B[k][j]
- output_valid  out  1  result beat present
- output_ready  in  1  consumer accepts result beat
- output_by_row  in  1  1 = row-wise drain, 0 = column-wise drain; sampled on the transfer edge
- output_last  out  1  marks the final beat of a result
- c_data_streaming  out  ACC_WIDTH×OUT_LANES  result beat; unused lanes are 0

## Operation
- Compute FSM states:
  - IDLE: input_ready=1. The first accepted beat latches K (len_input==0 is treated as 1) and signed_mode. If K==1, go to FLUSH; otherwise go to LOAD.
  - LOAD: input_ready=1. Accept the remaining K−1 beats, then go to FLUSH.
  - FLUSH: input_ready=0. Run ROWS+COLS−2 enabled cycles with zero operands, then go to DONE. If ROWS+COLS−2==0, go straight to DONE.
  - DONE: input_ready=0. Hold until the output buffer is free, then transfer, clear all accumulators and go to IDLE.
- Array enable = (accepted beat) OR (state==FLUSH).
  - Input skew registers, cell pass-through registers and accumulators advance only on enable.
  - During an input stall in LOAD, the whole array freezes.
- Skew: A lane i is delayed i enabled cycles and B lane j is delayed j enabled cycles. Cell (i,j) therefore sees operand pair k on enabled cycle k+i+j.
- Cell arithmetic:
  - acc += a·b, using DATA_WIDTH×DATA_WIDTH products.
  - Operands are sign-extended when the job's signed_mode=1, zero-extended otherwise.
  - Products are extended to ACC_WIDTH before accumulation; overflow wraps.
- Output buffer: a ROWS×COLS register set plus a beat counter.
  - The buffer is free when it is empty, or when its last beat handshakes in the current cycle. In the latter case the transfer occurs on the same edge and output_valid stays high.
  - Row mode: ROWS beats, beat r = C[r][0..COLS−1] on lanes 0..COLS−1.
  - Column mode: COLS beats, beat c = C[0..ROWS−1][c] on lanes 0..ROWS−1.
  - A beat advances only on output_valid && output_ready.
  - output_valid and c_data_streaming hold steady while output_ready=0.
- Reset mid-operation:
  - Compute FSM goes to IDLE; accumulators, skew and buffer are cleared; output_valid drops.
  - Partial data never contaminates a later job.

## Timing
- Reset values:
  - output_valid=0, output_last=0, c_data_streaming all 0.
  - input_ready=1 from the first cycle after reset; beats presented while reset is high are ignored.
- Latency, with no input stalls and a free buffer:
  - First beat accepted in cycle t0; transfer on the edge ending cycle t0+K+ROWS+COLS−2.
  - output_valid=1 in cycle t0+K+ROWS+COLS−1.
  - Each input stall cycle adds one cycle.
- Back-to-back throughput: a new first beat can be accepted in the cycle after the transfer. Minimum job period is K+ROWS+COLS−1 cycles.
- output_last=1 exactly on the ROWS-th (row mode) or COLS-th (column mode) beat, and only while output_valid=1.
- output_by_row is ignored except on the transfer edge.

## Test plan
- Non-square unsigned job (ROWS=2, COLS=3, K=2): beats a={1,3},b={1,0,2} then a={2,4},b={0,1,3}, output_by_row=1, output_ready=1 -> output_valid rises 6 cycles after the first beat; beats {1,2,8} then {3,4,18} with output_last on the second beat. Same job with output_by_row=0 -> beats {1,3,0},{2,4,0},{8,18,0}.
- Signed mode (K=1): a=0xFF, b=0x02 with signed_mode=1 -> element 0xFFFFFFFE (−2). Same operands with signed_mode=0 -> 510.
- Double buffering under back-pressure: two jobs back-to-back with output_ready=0 -> job 2 stalls in DONE with input_ready=0. Raising output_ready drains job 1; on its last handshake job 2 transfers on the same edge, output_valid never drops, and job 2's data is correct.
- Input stalls: the first job of this list with input_valid low for 3 cycles between beats -> identical result; output_valid is 3 cycles later.
- Reset mid-job: assert reset during LOAD and again while output_valid=1 -> output_valid=0 next cycle. A following fresh job yields exact results with no residue.
- len_input=0: one beat with a={5,…}, b={7,…} -> treated as K=1; C[0][0]=35.

Source files
------------

// File: rtl/sum_stationary_dbuf.sv
// Output-stationary ROWS x COLS multiply-accumulate grid computing C = A*B with a per-job K,
// signed/unsigned operands and a double-buffered result drain (row-wise or column-wise beats).
module sum_stationary_dbuf #(
    parameter int DATA_WIDTH   = 8,
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int COUNTER_BITS = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_LANES    = (ROWS > COLS) ? ROWS : COLS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           input_valid,
    output logic                           input_ready,
    input  logic [COUNTER_BITS-1:0]        len_input,
    input  logic                           signed_mode,
    input  logic [DATA_WIDTH*ROWS-1:0]     a_data,
    input  logic [DATA_WIDTH*COLS-1:0]     b_data,
    output logic                           output_valid,
    input  logic                           output_ready,
    input  logic                           output_by_row,
    output logic                           output_last,
    output logic [ACC_WIDTH*OUT_LANES-1:0] c_data_streaming
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam bit NO_FLUSH = (ROWS + COLS == 2);
    localparam logic [1:0] AFTER_LOAD = NO_FLUSH ? S_DONE : S_FLUSH;
    localparam logic [COUNTER_BITS-1:0] FLUSH_LAST = NO_FLUSH ? '0 : COUNTER_BITS'(ROWS + COLS - 3);
    localparam int BEAT_W = $clog2(OUT_LANES + 1);

    typedef logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] mat_t;

    logic [1:0]              state_r;
    logic [COUNTER_BITS-1:0] k_r;
    logic [COUNTER_BITS-1:0] cnt_r;
    logic                    signed_r;
    logic                    cur_signed_s;
    logic                    accept_s;
    logic                    en_s;
    logic                    buf_free_s;
    logic                    transfer_s;
    logic [DATA_WIDTH-1:0]   a_in_s   [ROWS];
    logic [DATA_WIDTH-1:0]   b_in_s   [COLS];
    logic [DATA_WIDTH-1:0]   a_edge_s [ROWS];
    logic [DATA_WIDTH-1:0]   b_edge_s [COLS];
    logic [DATA_WIDTH-1:0]   a_cell_s [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   b_cell_s [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   a_pass_r [ROWS][COLS-1];
    logic [DATA_WIDTH-1:0]   b_pass_r [ROWS-1][COLS];
    mat_t                    acc_r;
    mat_t                    buf_r;
    logic [BEAT_W-1:0]       beat_r;
    logic                    by_row_r;

    function automatic logic [ACC_WIDTH-1:0] mac_product(input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b,
                                                         input logic sgn);
        logic signed [DATA_WIDTH:0]     sa;
        logic signed [DATA_WIDTH:0]     sb;
        logic signed [2*DATA_WIDTH+1:0] p;
        sa = $signed({sgn & a[DATA_WIDTH-1], a});
        sb = $signed({sgn & b[DATA_WIDTH-1], b});
        p  = sa * sb;
        return ACC_WIDTH'(p);
    endfunction

    function automatic logic [ACC_WIDTH*OUT_LANES-1:0] pick_beat(input mat_t m,
                                                                 input logic [BEAT_W-1:0] beat,
                                                                 input logic by_row);
        logic [ACC_WIDTH*OUT_LANES-1:0] lanes;
        lanes = '0;
        if (by_row) begin
            for (int r = 0; r < ROWS; r++) begin
                if (beat == BEAT_W'(r)) begin
                    for (int c = 0; c < COLS; c++) lanes[c*ACC_WIDTH +: ACC_WIDTH] = m[r][c];
                end
            end
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (beat == BEAT_W'(c)) begin
                    for (int r = 0; r < ROWS; r++) lanes[r*ACC_WIDTH +: ACC_WIDTH] = m[r][c];
                end
            end
        end
        return lanes;
    endfunction

    assign input_ready = (state_r == S_IDLE) || (state_r == S_LOAD);
    assign accept_s    = input_valid && input_ready;
    assign en_s        = accept_s || (state_r == S_FLUSH);
    assign buf_free_s  = !output_valid || (output_ready && output_last);
    assign transfer_s  = (state_r == S_DONE) && buf_free_s;
    // The first beat's product is formed before signed_r has latched the job's mode.
    assign cur_signed_s = (state_r == S_IDLE) ? signed_mode : signed_r;

    // Operand lanes, zeroed whenever no beat is accepted (flush cycles)
    always_comb begin
        for (int i = 0; i < ROWS; i++) a_in_s[i] = accept_s ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int j = 0; j < COLS; j++) b_in_s[j] = accept_s ? b_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        if (i == 0) begin : g_direct
            assign a_edge_s[i] = a_in_s[i];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly_r [i];
            // A lane i delay line, i enabled cycles deep
            always_ff @(posedge clk) begin
                if (reset || transfer_s) begin
                    for (int d = 0; d < i; d++) dly_r[d] <= '0;
                end else if (en_s) begin
                    dly_r[0] <= a_in_s[i];
                    for (int d = 1; d < i; d++) dly_r[d] <= dly_r[d-1];
                end
            end
            assign a_edge_s[i] = dly_r[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        if (j == 0) begin : g_direct
            assign b_edge_s[j] = b_in_s[j];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly_r [j];
            // B lane j delay line, j enabled cycles deep
            always_ff @(posedge clk) begin
                if (reset || transfer_s) begin
                    for (int d = 0; d < j; d++) dly_r[d] <= '0;
                end else if (en_s) begin
                    dly_r[0] <= b_in_s[j];
                    for (int d = 1; d < j; d++) dly_r[d] <= dly_r[d-1];
                end
            end
            assign b_edge_s[j] = dly_r[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_cell_s[i][j] = a_edge_s[i];
            end else begin : g_a_pass
                assign a_cell_s[i][j] = a_pass_r[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_cell_s[i][j] = b_edge_s[j];
            end else begin : g_b_pass
                assign b_cell_s[i][j] = b_pass_r[i-1][j];
            end
        end
    end

    // Cell pass-through registers and accumulators; cleared when a result is handed to the buffer
    always_ff @(posedge clk) begin
        if (reset || transfer_s) begin
            acc_r <= '0;
            for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS - 1; j++) a_pass_r[i][j] <= '0;
            for (int i = 0; i < ROWS - 1; i++) for (int j = 0; j < COLS; j++) b_pass_r[i][j] <= '0;
        end else if (en_s) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    acc_r[i][j] <= acc_r[i][j] + mac_product(a_cell_s[i][j], b_cell_s[i][j], cur_signed_s);
                end
            end
            for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS - 1; j++) a_pass_r[i][j] <= a_cell_s[i][j];
            for (int i = 0; i < ROWS - 1; i++) for (int j = 0; j < COLS; j++) b_pass_r[i][j] <= b_cell_s[i][j];
        end
    end

    // Compute FSM: cnt_r counts accepted beats in LOAD, then flush cycles in FLUSH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            k_r      <= '0;
            cnt_r    <= '0;
            signed_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        k_r      <= (len_input == '0) ? COUNTER_BITS'(1) : len_input;
                        signed_r <= signed_mode;
                        if (len_input <= COUNTER_BITS'(1)) begin
                            state_r <= AFTER_LOAD;
                            cnt_r   <= '0;
                        end else begin
                            state_r <= S_LOAD;
                            cnt_r   <= COUNTER_BITS'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        if (cnt_r == k_r - COUNTER_BITS'(1)) begin
                            state_r <= AFTER_LOAD;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + COUNTER_BITS'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt_r == FLUSH_LAST) begin
                        state_r <= S_DONE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + COUNTER_BITS'(1);
                    end
                end
                S_DONE: begin
                    if (transfer_s) state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Result buffer and registered drain; a transfer may land on the same edge as the last handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_r            <= '0;
            beat_r           <= '0;
            by_row_r         <= 1'b0;
            output_valid     <= 1'b0;
            output_last      <= 1'b0;
            c_data_streaming <= '0;
        end else if (transfer_s) begin
            buf_r            <= acc_r;
            beat_r           <= '0;
            by_row_r         <= output_by_row;
            output_valid     <= 1'b1;
            output_last      <= output_by_row ? (ROWS == 1) : (COLS == 1);
            c_data_streaming <= pick_beat(acc_r, '0, output_by_row);
        end else if (output_valid && output_ready) begin
            if (output_last) begin
                output_valid     <= 1'b0;
                output_last      <= 1'b0;
                c_data_streaming <= '0;
            end else begin
                beat_r           <= beat_r + BEAT_W'(1);
                output_last      <= by_row_r ? (beat_r + BEAT_W'(1) == BEAT_W'(ROWS - 1))
                                             : (beat_r + BEAT_W'(1) == BEAT_W'(COLS - 1));
                c_data_streaming <= pick_beat(buf_r, beat_r + BEAT_W'(1), by_row_r);
            end
        end
    end
endmodule

// File: tb/tb_sum_stationary_dbuf.sv
// Directed bench for sum_stationary_dbuf on a 2x3 grid: latency, drain modes, signedness,
// double buffering under back-pressure, input stalls, mid-job reset and len_input=0.
module tb_sum_stationary_dbuf;
    localparam int DW = 8, R = 2, C = 3, CB = 16, AW = 32, OL = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              input_valid;
    logic              input_ready;
    logic [CB-1:0]     len_input;
    logic              signed_mode;
    logic [DW*R-1:0]   a_data;
    logic [DW*C-1:0]   b_data;
    logic              output_valid;
    logic              output_ready;
    logic              output_by_row;
    logic              output_last;
    logic [AW*OL-1:0]  c_data_streaming;

    int checks = 0, failures = 0, cycle = 0, t0 = 0;

    sum_stationary_dbuf #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .COUNTER_BITS(CB), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
        .len_input(len_input), .signed_mode(signed_mode), .a_data(a_data), .b_data(b_data),
        .output_valid(output_valid), .output_ready(output_ready), .output_by_row(output_by_row),
        .output_last(output_last), .c_data_streaming(c_data_streaming)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [AW*OL-1:0] obs, input logic [AW*OL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW*OL-1:0] row3(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
        return {x2, x1, x0};
    endfunction

    task automatic send_beat(input logic [CB-1:0] len, input logic sgn, input logic [DW*R-1:0] a, input logic [DW*C-1:0] b);
        input_valid = 1'b1;
        len_input   = len;
        signed_mode = sgn;
        a_data      = a;
        b_data      = b;
        tick();
        input_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        for (int n = 0; n < limit && output_valid !== 1'b1; n++) tick();
    endtask

    task automatic wait_ready(input int limit);
        for (int n = 0; n < limit && input_ready !== 1'b1; n++) tick();
    endtask

    // The standard K=2 job: A = [[1,2],[3,4]], B = [[1,0,2],[0,1,3]] -> C = [[1,2,8],[3,4,18]]
    task automatic send_std_job(input int stall);
        send_beat(16'd2, 1'b0, {8'd3, 8'd1}, {8'd2, 8'd0, 8'd1});
        for (int n = 0; n < stall; n++) tick();
        send_beat(16'd2, 1'b0, {8'd4, 8'd2}, {8'd3, 8'd1, 8'd0});
    endtask

    initial begin
        reset = 1'b1; input_valid = 1'b0; len_input = '0; signed_mode = 1'b0;
        a_data = '0; b_data = '0; output_ready = 1'b1; output_by_row = 1'b1;
        tick(); tick();
        send_beat(16'd1, 1'b0, {8'd9, 8'd9}, {8'd9, 8'd9, 8'd9});
        reset = 1'b0;
        chk("reset_ready", input_ready, 1);
        chk("reset_valid", output_valid, 0);
        chk("reset_last", output_last, 0);
        chk("reset_data", c_data_streaming, 0);

        // Row-mode drain
        t0 = cycle;
        send_std_job(0);
        chk("flush_not_ready", input_ready, 0);
        wait_valid(30);
        chk("row_latency", cycle - t0, 6);
        chk("row_beat0", c_data_streaming, row3(1, 2, 8));
        chk("row_last0", output_last, 0);
        tick();
        chk("row_beat1", c_data_streaming, row3(3, 4, 18));
        chk("row_last1", output_last, 1);
        tick();
        chk("row_done_valid", output_valid, 0);
        chk("row_done_last", output_last, 0);

        // Column-mode drain with back-pressure; output_by_row changes after the transfer are ignored
        output_ready = 1'b0; output_by_row = 1'b0;
        send_std_job(0);
        wait_valid(30);
        output_by_row = 1'b1;
        chk("col_beat0", c_data_streaming, row3(1, 3, 0));
        tick(); tick();
        chk("col_hold_valid", output_valid, 1);
        chk("col_hold_data", c_data_streaming, row3(1, 3, 0));
        output_ready = 1'b1;
        tick();
        chk("col_beat1", c_data_streaming, row3(2, 4, 0));
        chk("col_last1", output_last, 0);
        tick();
        chk("col_beat2", c_data_streaming, row3(8, 18, 0));
        chk("col_last2", output_last, 1);
        tick();
        chk("col_done_valid", output_valid, 0);

        // Signed versus unsigned with K=1
        t0 = cycle;
        send_beat(16'd1, 1'b1, {8'd0, 8'hFF}, {8'd0, 8'd0, 8'd2});
        wait_valid(30);
        chk("k1_latency", cycle - t0, 5);
        chk("signed_elem", c_data_streaming, row3(32'hFFFF_FFFE, 0, 0));
        tick(); tick();
        send_beat(16'd1, 1'b0, {8'd0, 8'hFF}, {8'd0, 8'd0, 8'd2});
        wait_valid(30);
        chk("unsigned_elem", c_data_streaming, row3(510, 0, 0));
        tick(); tick();

        // Double buffering: job 2 waits in DONE until job 1's last beat handshakes
        output_ready = 1'b0;
        send_std_job(0);
        wait_ready(30);
        send_beat(16'd1, 1'b0, {8'd2, 8'd1}, {8'd5, 8'd4, 8'd3});
        for (int n = 0; n < 8; n++) tick();
        chk("db_stall_ready", input_ready, 0);
        chk("db_valid", output_valid, 1);
        chk("db_hold", c_data_streaming, row3(1, 2, 8));
        output_ready = 1'b1;
        tick();
        chk("db_j1_beat1", c_data_streaming, row3(3, 4, 18));
        chk("db_j1_last", output_last, 1);
        tick();
        chk("db_valid_kept", output_valid, 1);
        chk("db_j2_beat0", c_data_streaming, row3(3, 4, 5));
        chk("db_j2_last0", output_last, 0);
        chk("db_ready_back", input_ready, 1);
        tick();
        chk("db_j2_beat1", c_data_streaming, row3(6, 8, 10));
        chk("db_j2_last1", output_last, 1);
        tick();
        chk("db_done_valid", output_valid, 0);

        // Three stall cycles between the beats
        t0 = cycle;
        send_std_job(3);
        wait_valid(30);
        chk("stall_latency", cycle - t0, 9);
        chk("stall_beat0", c_data_streaming, row3(1, 2, 8));
        tick();
        chk("stall_beat1", c_data_streaming, row3(3, 4, 18));
        tick();

        // Reset during LOAD, then while a result is held
        send_beat(16'd2, 1'b0, {8'd9, 8'd9}, {8'd9, 8'd9, 8'd9});
        chk("load_state_ready", input_ready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_load_valid", output_valid, 0);
        output_ready = 1'b0;
        send_std_job(0);
        wait_valid(30);
        chk("pre_rst_valid", output_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_out_valid", output_valid, 0);
        chk("rst_out_data", c_data_streaming, 0);
        output_ready = 1'b1;
        t0 = cycle;
        send_std_job(0);
        wait_valid(30);
        chk("fresh_latency", cycle - t0, 6);
        chk("fresh_beat0", c_data_streaming, row3(1, 2, 8));
        tick();
        chk("fresh_beat1", c_data_streaming, row3(3, 4, 18));
        tick();

        // len_input == 0 behaves as K == 1
        t0 = cycle;
        send_beat(16'd0, 1'b0, {8'd0, 8'd5}, {8'd0, 8'd0, 8'd7});
        wait_valid(30);
        chk("len0_latency", cycle - t0, 5);
        chk("len0_elem", c_data_streaming, row3(35, 0, 0));
        tick(); tick();
        chk("len0_done_valid", output_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
